// File: rtl/operand_fwd_unit.sv
// rtl/operand_fwd_unit.sv - operand gather/forward with RAW hazard stall and stall statistics
module operand_fwd_unit #(
  parameter int NSTAGE    = 7,
  parameter int MAX_STALL = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [6:0]              ra_addr,
  input  logic [6:0]              rb_addr,
  input  logic [6:0]              rc_addr,
  input  logic                    ra_use,
  input  logic                    rb_use,
  input  logic                    rc_use,
  input  logic [127:0]            rf_ra,
  input  logic [127:0]            rf_rb,
  input  logic [127:0]            rf_rc,
  input  logic [143*NSTAGE-1:0]   even_stages,
  input  logic [143*NSTAGE-1:0]   odd_stages,
  input  logic [6:0]              wb_even_addr,
  input  logic [6:0]              wb_odd_addr,
  input  logic [127:0]            wb_even_data,
  input  logic [127:0]            wb_odd_data,
  input  logic                    wb_even_en,
  input  logic                    wb_odd_en,
  output logic                    out_valid,
  output logic [127:0]            out_ra,
  output logic [127:0]            out_rb,
  output logic [127:0]            out_rc,
  output logic [15:0]             stall_cnt,
  output logic                    stall_err
);

  localparam int REC_W = 143;
  localparam int RUN_W = $clog2(MAX_STALL + 2) + 1;
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q;
  logic [128:0]     res_a, res_b, res_c;
  logic             hazard, stall_cyc, accept;
  logic [127:0]     op_a, op_b, op_c;

  // Resolve one source register: {ready, data}. Youngest in-flight writer wins,
  // even before odd at equal age; a writer younger than its latency blocks issue.
  function automatic logic [128:0] resolve_op(
    input logic [6:0]              addr,
    input logic [127:0]            rf,
    input logic [REC_W*NSTAGE-1:0] ev,
    input logic [REC_W*NSTAGE-1:0] od,
    input logic [6:0]              we_addr,
    input logic [127:0]            we_data,
    input logic                    we_en,
    input logic [6:0]              wo_addr,
    input logic [127:0]            wo_data,
    input logic                    wo_en
  );
    logic                    found;
    logic                    ready;
    logic [127:0]            data;
    logic [3:0]              lat;
    logic [REC_W*NSTAGE-1:0] bus;
    int                      base;
    found = 1'b0;
    ready = 1'b1;
    data  = rf;
    lat   = 4'd0;
    bus   = '0;
    base  = 0;
    for (int k = 1; k <= NSTAGE; k++) begin
      for (int p = 0; p < 2; p++) begin
        bus  = (p == 0) ? ev : od;
        base = (k - 1) * REC_W;
        if (!found && bus[base + 142] && (bus[base + 131 +: 7] == addr)) begin
          found = 1'b1;
          lat   = (bus[base + 138 +: 4] == 4'd0) ? 4'd1 : bus[base + 138 +: 4];
          if (k >= int'(lat)) data = bus[base + 3 +: 128];
          else                ready = 1'b0;
        end
      end
    end
    if (!found && we_en && (we_addr == addr)) begin
      found = 1'b1;
      data  = we_data;
    end
    if (!found && wo_en && (wo_addr == addr)) begin
      data  = wo_data;
    end
    return {ready, data};
  endfunction

  // Per-operand forwarding network and hazard detection
  always_comb begin
    res_a = resolve_op(ra_addr, rf_ra, even_stages, odd_stages, wb_even_addr, wb_even_data,
                       wb_even_en, wb_odd_addr, wb_odd_data, wb_odd_en);
    res_b = resolve_op(rb_addr, rf_rb, even_stages, odd_stages, wb_even_addr, wb_even_data,
                       wb_even_en, wb_odd_addr, wb_odd_data, wb_odd_en);
    res_c = resolve_op(rc_addr, rf_rc, even_stages, odd_stages, wb_even_addr, wb_even_data,
                       wb_even_en, wb_odd_addr, wb_odd_data, wb_odd_en);
    op_a      = ra_use ? res_a[127:0] : rf_ra;
    op_b      = rb_use ? res_b[127:0] : rf_rb;
    op_c      = rc_use ? res_c[127:0] : rf_rc;
    hazard    = (ra_use & ~res_a[128]) | (rb_use & ~res_b[128]) | (rc_use & ~res_c[128]);
    req_ready = ~hazard & ~flush;
    accept    = req_valid & req_ready;
    stall_cyc = req_valid & hazard & ~flush;
  end

  // Issue FSM next state: stay stalled only while the blocked request persists
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stall_cyc) state_d = STALL;
      STALL:   if (!stall_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand output registers; out_* hold when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ra    <= '0;
      out_rb    <= '0;
      out_rc    <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_ra <= op_a;
        out_rb <= op_b;
        out_rc <= op_c;
      end
    end
  end

  // Stall statistics: saturating total, consecutive-run counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      run_q     <= '0;
      stall_err <= 1'b0;
    end else if (stall_cyc) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (state_q == IDLE) begin
        run_q <= RUN_W'(1);
        if (RUN_W'(1) >= RUN_LIMIT) stall_err <= 1'b1;
      end else begin
        if (run_q != RUN_LIMIT) run_q <= run_q + RUN_W'(1);
        if (run_q + RUN_W'(1) >= RUN_LIMIT) stall_err <= 1'b1;
      end
    end else begin
      run_q <= '0;
    end
  end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// tb/tb_operand_fwd_unit.sv - self-checking bench for operand_fwd_unit
module tb_operand_fwd_unit;

  localparam int NSTAGE    = 7;
  localparam int MAX_STALL = 8;

  typedef struct {
    bit         wr;
    bit [6:0]   dst;
    bit [3:0]   lat;
    bit [127:0] res;
    bit [2:0]   unit;
  } rec_t;

  typedef struct {
    bit         hit;
    bit         ok;
    bit [127:0] val;
  } cand_t;

  logic                  clk, rst, flush, req_valid, req_ready;
  logic [6:0]            ra_addr, rb_addr, rc_addr;
  logic                  ra_use, rb_use, rc_use;
  logic [127:0]          rf_ra, rf_rb, rf_rc;
  logic [143*NSTAGE-1:0] even_stages, odd_stages;
  logic [6:0]            wb_even_addr, wb_odd_addr;
  logic [127:0]          wb_even_data, wb_odd_data;
  logic                  wb_even_en, wb_odd_en;
  logic                  out_valid;
  logic [127:0]          out_ra, out_rb, out_rc;
  logic [15:0]           stall_cnt;
  logic                  stall_err;

  rec_t ev[NSTAGE];
  rec_t od[NSTAGE];

  int         n_pass, n_total;
  bit         e_valid, e_err, last_rdy;
  bit [127:0] e_ra, e_rb, e_rc;
  int         e_cnt, e_run;

  operand_fwd_unit #(.NSTAGE(NSTAGE), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_use(ra_use), .rb_use(rb_use), .rc_use(rc_use),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rc(rf_rc),
    .even_stages(even_stages), .odd_stages(odd_stages),
    .wb_even_addr(wb_even_addr), .wb_odd_addr(wb_odd_addr),
    .wb_even_data(wb_even_data), .wb_odd_data(wb_odd_data),
    .wb_even_en(wb_even_en), .wb_odd_en(wb_odd_en),
    .out_valid(out_valid), .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic rec_t mkrec(input bit [6:0] dst, input bit [3:0] lat, input bit [127:0] res);
    rec_t r;
    r.wr = 1'b1; r.dst = dst; r.lat = lat; r.res = res; r.unit = 3'($urandom);
    return r;
  endfunction

  function automatic rec_t norec();
    rec_t r;
    r.wr = 1'b0; r.dst = 7'($urandom); r.lat = 4'($urandom);
    r.res = {$urandom, $urandom, $urandom, $urandom}; r.unit = 3'($urandom);
    return r;
  endfunction

  function automatic bit [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_stages();
    for (int k = 0; k < NSTAGE; k++) begin
      even_stages[k*143 +: 143] = {ev[k].wr, ev[k].lat, ev[k].dst, ev[k].res, ev[k].unit};
      odd_stages[k*143 +: 143]  = {od[k].wr, od[k].lat, od[k].dst, od[k].res, od[k].unit};
    end
  endtask

  // Reference: list every potential producer oldest-last, take the first that writes addr
  function automatic void model_res(input bit [6:0] addr, input bit [127:0] rf,
                                    output bit rdy, output bit [127:0] d);
    cand_t q[$];
    cand_t c;
    int    need;
    for (int k = 0; k < NSTAGE; k++) begin
      need  = (ev[k].lat == 0) ? 1 : int'(ev[k].lat);
      c.hit = ev[k].wr && (ev[k].dst == addr); c.ok = (k + 1) >= need; c.val = ev[k].res;
      q.push_back(c);
      need  = (od[k].lat == 0) ? 1 : int'(od[k].lat);
      c.hit = od[k].wr && (od[k].dst == addr); c.ok = (k + 1) >= need; c.val = od[k].res;
      q.push_back(c);
    end
    c.hit = wb_even_en && (wb_even_addr == addr); c.ok = 1'b1; c.val = wb_even_data;
    q.push_back(c);
    c.hit = wb_odd_en && (wb_odd_addr == addr); c.ok = 1'b1; c.val = wb_odd_data;
    q.push_back(c);
    rdy = 1'b1;
    d   = rf;
    foreach (q[i]) begin
      if (q[i].hit) begin
        rdy = q[i].ok;
        if (q[i].ok) d = q[i].val;
        return;
      end
    end
  endfunction

  // One clock: check combinational ready, advance the model, then check registered outputs
  task automatic cycle();
    bit         ra_ok, rb_ok, rc_ok, haz, rdy;
    bit [127:0] da, db, dc;
    apply_stages();
    #1;
    model_res(ra_addr, rf_ra, ra_ok, da);
    model_res(rb_addr, rf_rb, rb_ok, db);
    model_res(rc_addr, rf_rc, rc_ok, dc);
    if (!ra_use) begin ra_ok = 1'b1; da = rf_ra; end
    if (!rb_use) begin rb_ok = 1'b1; db = rf_rb; end
    if (!rc_use) begin rc_ok = 1'b1; dc = rf_rc; end
    haz = !(ra_ok && rb_ok && rc_ok);
    rdy = !haz && !flush;
    last_rdy = rdy;
    chk("req_ready", req_ready, rdy);
    if (req_valid && rdy) begin
      e_valid = 1'b1; e_ra = da; e_rb = db; e_rc = dc;
    end else begin
      e_valid = 1'b0;
    end
    if (req_valid && haz && !flush) begin
      if (e_cnt < 65535) e_cnt++;
      e_run++;
      if (e_run >= MAX_STALL + 1) e_err = 1'b1;
    end else begin
      e_run = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, e_valid);
    chk("out_ra", out_ra, e_ra);
    chk("out_rb", out_rb, e_rb);
    chk("out_rc", out_rc, e_rc);
    chk("stall_cnt", stall_cnt, 16'(e_cnt));
    chk("stall_err", stall_err, e_err);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; req_valid = 1'b0;
    ra_addr = 7'd0; rb_addr = 7'd0; rc_addr = 7'd0;
    ra_use = 1'b1; rb_use = 1'b1; rc_use = 1'b1;
    rf_ra = rnd128(); rf_rb = rnd128(); rf_rc = rnd128();
    wb_even_en = 1'b0; wb_odd_en = 1'b0;
    wb_even_addr = 7'd0; wb_odd_addr = 7'd0;
    wb_even_data = rnd128(); wb_odd_data = rnd128();
    for (int k = 0; k < NSTAGE; k++) begin ev[k] = norec(); od[k] = norec(); end
  endtask

  task automatic model_reset();
    e_valid = 1'b0; e_err = 1'b0; e_ra = '0; e_rb = '0; e_rc = '0; e_cnt = 0; e_run = 0;
  endtask

  initial begin
    bit [127:0] a_val, r_val, r1, r2, d_val;
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    idle_inputs();
    apply_stages();
    model_reset();
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_ra", out_ra, 128'd0);
    chk("reset stall_cnt", stall_cnt, 16'd0);
    chk("reset stall_err", stall_err, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: plain register-file read, out_valid for exactly one cycle
    a_val = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
    rf_ra = a_val; ra_addr = 7'd12; req_valid = 1'b1;
    cycle();
    chk("t1 out_ra", out_ra, a_val);
    chk("t1 out_valid", out_valid, 1'b1);
    req_valid = 1'b0;
    cycle();
    chk("t1 out_valid drop", out_valid, 1'b0);
    chk("t1 stall_cnt", stall_cnt, 16'd0);

    // 2: even stage 2 ready result
    r_val = 128'h2222_0000_1111_0000_2222_0000_1111_0005;
    idle_inputs(); ev[1] = mkrec(7'd5, 4'd2, r_val); ra_addr = 7'd5; req_valid = 1'b1;
    cycle();
    chk("t2 out_ra", out_ra, r_val);
    chk("t2 stall_cnt", stall_cnt, 16'd0);

    // 3: latency-3 producer walks down the pipe, two stall cycles
    r_val = 128'h3333_3333_0000_0000_3333_3333_0000_0003;
    idle_inputs(); ev[0] = mkrec(7'd5, 4'd3, r_val); ra_addr = 7'd5; req_valid = 1'b1;
    cycle();
    chk("t3 ready st1", last_rdy, 1'b0);
    ev[1] = ev[0]; ev[0] = norec();
    cycle();
    chk("t3 ready st2", last_rdy, 1'b0);
    ev[2] = ev[1]; ev[1] = norec();
    cycle();
    chk("t3 ready st3", last_rdy, 1'b1);
    chk("t3 out_ra", out_ra, r_val);
    chk("t3 stall_cnt", stall_cnt, 16'd2);

    // 4: younger odd st1 beats older even st4; unused operand ignores it
    r1 = 128'h1111_1111_1111_1111_0000_0000_0000_0001;
    r2 = 128'h2222_2222_2222_2222_0000_0000_0000_0002;
    idle_inputs(); od[0] = mkrec(7'd9, 4'd1, r1); ev[3] = mkrec(7'd9, 4'd1, r2);
    rb_addr = 7'd9; req_valid = 1'b1;
    cycle();
    chk("t4 out_rb", out_rb, r1);
    od[0] = mkrec(7'd9, 4'd4, r1); rb_use = 1'b0;
    cycle();
    chk("t4 unused ready", last_rdy, 1'b1);
    chk("t4 unused out_rb", out_rb, rf_rb);

    // 5: WB forwarding over stale register file, then a 9-cycle hazard
    d_val = 128'hDDDD_0000_DDDD_0000_DDDD_0000_DDDD_0003;
    idle_inputs(); wb_even_en = 1'b1; wb_even_addr = 7'd3; wb_even_data = d_val;
    rc_addr = 7'd3; req_valid = 1'b1;
    cycle();
    chk("t5 out_rc", out_rc, d_val);
    idle_inputs(); ev[0] = mkrec(7'd5, 4'd7, rnd128()); ra_addr = 7'd5; req_valid = 1'b1;
    repeat (MAX_STALL) cycle();
    chk("t5 err after 8", stall_err, 1'b0);
    cycle();
    chk("t5 err after 9", stall_err, 1'b1);
    idle_inputs();
    cycle();
    chk("t5 err sticky", stall_err, 1'b1);
    chk("t5 stall_cnt", stall_cnt, 16'd11);

    // 6: flush during a stall
    idle_inputs(); ev[0] = mkrec(7'd7, 4'd6, rnd128()); ra_addr = 7'd7; req_valid = 1'b1;
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    chk("t6 flush ready", last_rdy, 1'b0);
    chk("t6 flush out_valid", out_valid, 1'b0);
    chk("t6 flush stall_cnt", stall_cnt, 16'd13);
    flush = 1'b0;
    cycle();
    ev[0] = norec();
    cycle();
    chk("t6 accept after flush", out_valid, 1'b1);

    // Randomized traffic over a small register space to provoke matches
    for (int n = 0; n < 2000; n++) begin
      req_valid = ($urandom_range(3) != 0);
      flush     = ($urandom_range(19) == 0);
      ra_addr = 7'($urandom_range(7)); rb_addr = 7'($urandom_range(7)); rc_addr = 7'($urandom_range(7));
      ra_use = 1'($urandom); rb_use = 1'($urandom); rc_use = 1'($urandom);
      rf_ra = rnd128(); rf_rb = rnd128(); rf_rc = rnd128();
      wb_even_en = ($urandom_range(2) == 0); wb_odd_en = ($urandom_range(2) == 0);
      wb_even_addr = 7'($urandom_range(7)); wb_odd_addr = 7'($urandom_range(7));
      wb_even_data = rnd128(); wb_odd_data = rnd128();
      for (int k = 0; k < NSTAGE; k++) begin
        ev[k] = ($urandom_range(9) < 3) ? mkrec(7'($urandom_range(7)), 4'($urandom_range(7)), rnd128()) : norec();
        od[k] = ($urandom_range(9) < 3) ? mkrec(7'($urandom_range(7)), 4'($urandom_range(7)), rnd128()) : norec();
      end
      cycle();
    end

    // Asynchronous reset in the middle of a stall
    idle_inputs(); rf_ra = 128'hFEED; req_valid = 1'b1;
    cycle();
    ev[0] = mkrec(7'd0, 4'd5, rnd128());
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_ra", out_ra, 128'd0);
    chk("rst stall_cnt", stall_cnt, 16'd0);
    chk("rst stall_err", stall_err, 1'b0);
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cycle();

    // Saturation of the total stall counter
    idle_inputs(); ev[0] = mkrec(7'd0, 4'd5, rnd128()); req_valid = 1'b1;
    apply_stages();
    repeat (65534) @(posedge clk);
    #1;
    chk("sat FFFE", stall_cnt, 16'hFFFE);
    @(posedge clk); #1;
    chk("sat FFFF", stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat hold", stall_cnt, 16'hFFFF);
    chk("sat err", stall_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
